// File: rtl/conv_result_reader.sv
`default_nettype none
// ============================================================================
// Module   : conv_result_reader
// Captures one OUT_DIM x OUT_DIM conv result and presents it one element at a
// time. Optional macro AUTO_SCAN_EN replaces the step pin with a timed advance.
// Revision : 1.0
// ============================================================================
module conv_result_reader #(
    parameter int OUT_DIM  = 4,
    parameter int DATA_W   = 8,
    parameter int SCAN_DIV = 12_000_000,
    parameter int IDX_W    = $clog2(OUT_DIM*OUT_DIM)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              ena,
    input  logic                              res_valid,
    input  logic [OUT_DIM*OUT_DIM*DATA_W-1:0] res_flat,
    input  logic                              step,
    input  logic                              restart,
    output logic [DATA_W-1:0]                 dout,
    output logic [IDX_W-1:0]                  idx,
    output logic                              busy,
    output logic                              last,
    output logic                              done,
    output logic                              ovr
);
    localparam int               N        = OUT_DIM*OUT_DIM;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N-1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SHOW = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            r_state, w_state_nx;
    logic [IDX_W-1:0]  r_idx, w_idx_nx;
    logic              r_ovr, w_ovr_nx;
    logic              w_capture;
    logic              w_advance;
    logic [DATA_W-1:0] r_buf [N];
    logic [DATA_W-1:0] r_dout;

    // Bits [1:0] synchronise the raw switch, bit [2] is the edge-detect history.
    logic [2:0] r_step_sync, r_rst_sync;
    logic       w_step_edge, w_restart_edge;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_step_sync <= '0;
            r_rst_sync  <= '0;
        end else begin
            r_step_sync <= {r_step_sync[1:0], step};
            r_rst_sync  <= {r_rst_sync[1:0], restart};
        end
    end

    assign w_step_edge    = r_step_sync[1] & ~r_step_sync[2];
    assign w_restart_edge = r_rst_sync[1]  & ~r_rst_sync[2];

`ifdef AUTO_SCAN_EN
    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [CNT_W-1:0] r_scan_cnt;
    logic             w_scan_tick;
    logic             w_unused_step;

    assign w_unused_step = w_step_edge;
    assign w_scan_tick   = (r_state == ST_SHOW) && (r_scan_cnt == CNT_W'(SCAN_DIV-1));
    assign w_advance     = w_scan_tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan_cnt <= '0;
        end else if (ena) begin
            if (w_capture || w_restart_edge || w_scan_tick)
                r_scan_cnt <= '0;
            else if (r_state == ST_SHOW)
                r_scan_cnt <= r_scan_cnt + CNT_W'(1);
        end
    end
`else
    logic [31:0] w_unused_cfg;

    assign w_unused_cfg = 32'(SCAN_DIV);
    assign w_advance    = w_step_edge;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_ovr   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_idx   <= w_idx_nx;
            r_ovr   <= w_ovr_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_idx_nx   = r_idx;
        w_ovr_nx   = r_ovr;
        w_capture  = 1'b0;
        busy       = (r_state == ST_SHOW);
        done       = (r_state == ST_DONE);
        last       = (r_state == ST_SHOW) && (r_idx == LAST_IDX);
        if (ena) begin
            case (r_state)
                ST_IDLE: begin
                    if (res_valid) begin
                        w_capture  = 1'b1;
                        w_idx_nx   = '0;
                        w_ovr_nx   = 1'b0;
                        w_state_nx = ST_SHOW;
                    end
                end
                ST_SHOW: begin
                    if (res_valid)
                        w_ovr_nx = 1'b1;
                    if (w_restart_edge) begin
                        w_idx_nx = '0;
                    end else if (w_advance) begin
                        if (r_idx == LAST_IDX)
                            w_state_nx = ST_DONE;
                        else
                            w_idx_nx = r_idx + IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    // A new result takes priority over a replay request.
                    if (res_valid) begin
                        w_capture  = 1'b1;
                        w_idx_nx   = '0;
                        w_ovr_nx   = 1'b0;
                        w_state_nx = ST_SHOW;
                    end else if (w_restart_edge) begin
                        w_idx_nx   = '0;
                        w_state_nx = ST_SHOW;
                    end
                end
                default: w_state_nx = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N; k++)
                r_buf[k] <= '0;
        end else if (w_capture) begin
            for (int k = 0; k < N; k++)
                r_buf[k] <= res_flat[k*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_dout <= '0;
        else
            r_dout <= r_buf[r_idx];
    end

    assign dout = r_dout;
    assign idx  = r_idx;
    assign ovr  = r_ovr;

endmodule
`default_nettype wire

// File: doc/conv_result_reader.md
# conv_result_reader

Readout engine for the convolution output feature map: captures one OUT_DIM×OUT_DIM result matrix from the convolution layer on a valid pulse and presents it one element at a time on the dedicated output pins. It is the output-side counterpart of the switch-driven row loader. The operator steps through the matrix with a switch and can replay it. Sits between the conv layer and `uo_out` / `uio_out` in the top-level wrapper.

## Interface
- OUT_DIM, 4: output matrix side (6×6 input, 3×3 kernel); N = OUT_DIM*OUT_DIM elements
- DATA_W, 8: bits per result element
- SCAN_DIV, 12_000_000: clocks per element in auto-scan (used only with AUTO_SCAN_EN)
- IDX_W, $clog2(N): width of element index
- clk  in  1  system clock
- rst_n  in  1  reset: rst_n, asynchronous, active-low
- ena  in  1  design enable; low freezes FSM and counters
- res_valid  in  1  one-cycle pulse: res_flat holds a complete result
- res_flat  in  N*DATA_W  element k = res_flat[k*DATA_W +: DATA_W], k = row*OUT_DIM+col
- step  in  1  raw switch level; rising edge advances one element
- restart  in  1  raw switch level; rising edge rewinds to element 0
- dout  out  DATA_W  currently presented element (registered)
- idx  out  IDX_W  index of presented element
- busy  out  1  matrix being presented
- last  out  1  idx == N-1 while presenting
- done  out  1  all elements stepped past
- ovr  out  1  sticky: res_valid arrived while busy

## Operation
- step and restart each pass a 2-FF synchronizer, then a rising-edge detector (third register); edges are one-cycle internal pulses.
- Capture buffer: N×DATA_W registers, written only on accepted res_valid.
- States IDLE, SHOW, DONE.
- IDLE: res_valid & ena -> capture all elements, idx=0, ovr=0, go SHOW. step/restart edges ignored.
- SHOW: busy=1. Step edge: idx<N-1 -> idx+1; idx==N-1 -> DONE. Restart edge -> idx=0. Restart wins over a simultaneous step. res_valid -> buffer untouched, ovr=1.
- DONE: done=1, busy=0, dout/idx hold element N-1. Restart edge -> SHOW, idx=0. res_valid -> recapture as in IDLE, clears ovr. res_valid wins over a simultaneous restart.
- dout = buffer[idx], registered; updates the cycle after idx changes.
- last = (state==SHOW) && idx==N-1.
- ena low: state, idx, buffer and auto-scan counter hold. Synchronizers keep running. Edges and res_valid occurring while ena is low are dropped.
- Unsigned index arithmetic. No wrap from N-1 to 0 except via restart or capture.

## Timing
- Reset values: dout=0, idx=0, busy=0, last=0, done=0, ovr=0, state=IDLE, buffer=0, synchronizers=0.
- Async reset asserted mid-presentation returns to IDLE immediately. The captured matrix is lost.
- res_valid sampled at edge T: busy=1 and idx=0 after T; dout=element 0 after T+1.
- Pin rising edge to idx change: 3 clocks (2 sync + edge detect), then +1 clock to dout.
- Holding step high produces one advance; a new advance needs a low level of at least 2 clocks.
- ovr sets the cycle after the offending res_valid.

## Configuration
- AUTO_SCAN_EN defined: a counter runs in SHOW. When it reaches SCAN_DIV-1 it generates an internal step and clears. It also clears on capture, restart and any advance. The step pin is ignored; restart still works. The counter holds in IDLE/DONE, so there is no auto-wrap.
- AUTO_SCAN_EN undefined: no counter is synthesized. Advancing is by the step pin only, and SCAN_DIV is unused.

## Test plan
(OUT_DIM=4, DATA_W=8; element k = 8'h10+k)
- Reset, no activity -> dout=0, idx=0, busy=0, done=0, ovr=0 indefinitely; step edges have no effect in IDLE.
- res_valid pulse -> busy=1 next cycle; dout=8'h10 the cycle after. 15 step edges -> idx 15, dout=8'h1F, last=1. 16th edge -> done=1, busy=0, last=0, dout stays 8'h1F.
- At idx=5, pulse restart and step on the same cycle -> idx=0, dout=8'h10; step level held 20 cycles -> exactly one advance to idx=1.
- In SHOW, second res_valid with different data (8'hA0+k) -> ovr=1, dout continues from the original 8'h1k values. Reach DONE, res_valid -> dout=8'hA0, ovr=0.
- In SHOW at idx=7, assert rst_n low asynchronously mid-cycle -> all outputs 0 immediately, state IDLE; ena low for 50 cycles with step edges -> idx unchanged.
- AUTO_SCAN_EN, SCAN_DIV=10 -> after capture idx increments every 10 clocks, reaching done after 160 clocks; step pin toggling has no effect.
